// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_tx / spi_rx pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } spi_rx_state_t;

  localparam int SPI_DEFAULT_WIDTH   = 8;
  // Shortest data_clk high or low phase, in clk_in cycles, that the receiver resolves.
  localparam int SPI_MIN_HALF_PERIOD = 3;

  // Bit positions of the pins inside the bundled synchroniser vector.
  localparam int SPI_PIN_DATA = 0;
  localparam int SPI_PIN_CLK  = 1;
  localparam int SPI_PIN_SEL  = 2;

  // Idle pin levels: data don't-care (0), data_clk low, select high (inactive).
  localparam logic [2:0] SPI_PIN_IDLE = 3'b100;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-bit pin synchroniser with history flop and registered rise/fall detect.
// Latency: STAGES+1 clk_in cycles from pin change to level/rise/fall outputs.
// Backpressure: none; outputs are free-running levels and one-cycle pulses.
module spi_pin_sync #(
  parameter int                WIDTH     = 3,
  parameter int                STAGES    = 2,   // minimum 2 for metastability settling
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] hist_q, hist_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Shift pins through the synchroniser chain and compare the last stage with history.
  always_comb begin
    sync_d[0] = pin_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~hist_q;
    fall_d = ~sync_q[STAGES-1] & hist_q;
  end

  // Preset to idle pin levels so reset release never looks like an edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RESET_VAL;
      end
      hist_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // History holds the level that the registered edge pulses refer to, keeping them aligned.
  assign level_out = hist_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 receiver, MSB first, active-low select, oversampled on clk_in.
// Latency: data_valid_out SYNC_STAGES+2 cycles after the final data_clk high is first captured.
// Backpressure: none; words are presented as one-cycle pulses and data_out holds the last word.
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  frame_err_out,
  output logic                  overrun_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] SETTLE_CNT = SW'(SYNC_STAGES + 1);

  logic [2:0] pins, level, rise, fall;
  logic       data_s, clk_rise, sel_rise, sel_fall, sel_lvl, settled;
  logic       unused_pins;

  spi_rx_state_t         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  commit_q, commit_d;
  logic                  armed_q, armed_d;
  logic [SW-1:0]         settle_q, settle_d;

  assign pins = {sel_in, data_clk_in, data_in};

  spi_pin_sync #(
    .WIDTH     (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (SPI_PIN_IDLE)
  ) u_pin_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pin_in    (pins),
    .level_out (level),
    .rise_out  (rise),
    .fall_out  (fall)
  );

  assign data_s   = level[SPI_PIN_DATA];
  assign clk_rise = rise[SPI_PIN_CLK];
  assign sel_rise = rise[SPI_PIN_SEL];
  assign sel_fall = fall[SPI_PIN_SEL];
  assign sel_lvl  = level[SPI_PIN_SEL];
  assign settled  = (settle_q == SETTLE_CNT);
  assign unused_pins = ^{level[SPI_PIN_CLK], rise[SPI_PIN_DATA], fall[SPI_PIN_DATA], fall[SPI_PIN_CLK]};

  // Next-state, datapath and pulse generation; the completed word is published one cycle after capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    commit_d = 1'b0;
    settle_d = settled ? settle_q : settle_q + SW'(1);
    // The synchroniser shows preset levels right after reset; only trust select high once flushed,
    // so a select already low at reset release cannot start a frame.
    armed_d  = armed_q | (settled & sel_lvl);

    if (commit_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (armed_q && sel_fall) begin
          state_d = RECV;
        end
      end
      RECV: begin
        // Select release wins over a coincident clock rise.
        if (sel_rise) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else if (clk_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], data_s};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            commit_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        // Counter saturates here; extra clocks only flag an overrun.
        if (sel_rise) begin
          state_d = IDLE;
        end else if (clk_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      commit_q <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      commit_q <= commit_d;
      armed_q  <= armed_d;
      settle_q <= settle_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign frame_err_out  = ferr_q;
  assign overrun_out    = ovr_q;

endmodule
